// File: rtl/coef_load_pkg.sv
// Shared constants and FSM encoding for the FIR coefficient-RAM load master.
// Bus geometry: four banks of sixteen entries, bank selected by addr[5:4].
package coef_load_pkg;

    localparam int ADDR_W     = 6;
    localparam int BANK_DEPTH = 16;
    localparam int NUM_BANKS  = 4;
    localparam int MAX_COEF   = BANK_DEPTH * NUM_BANKS;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GUARD_IN  = 3'd1,
        ST_FETCH     = 3'd2,
        ST_WRITE     = 3'd3,
        ST_RD        = 3'd4,
        ST_CHK       = 3'd5,
        ST_GUARD_OUT = 3'd6,
        ST_DONE      = 3'd7
    } state_t;

endpackage

// File: rtl/coef_sum_acc.sv
// Modular (2^W) running sum with synchronous clear; clear takes priority over add.
module coef_sum_acc #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_sum
);

    logic [W-1:0] r_sum;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_en) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/coef_load_master.sv
// Coefficient-RAM load master: streams NUM_COEF coefficients onto the FIR RAM bus
// inside an update-flag window. Optional readback checksum: define COEF_READBACK_EN.
module coef_load_master
    import coef_load_pkg::*;
#(
    parameter int NUM_COEF  = 64,
    parameter int COEF_W    = 16,
    parameter int GUARD_CYC = 2
) (
    input  logic              iClk_12M,
    input  logic              iRsn,
    input  logic              iStart,
    input  logic              iCoefValid,
    input  logic [COEF_W-1:0] iCoefData,
    output logic              oCoefReady,
    output logic [ADDR_W-1:0] oAddr,
    output logic              oCsn,
    output logic              oWrn,
    output logic [COEF_W-1:0] oWrDt,
    input  logic [COEF_W-1:0] iRdDt,
    output logic              oUpdateFlag,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErr
);

    localparam int                GCNT_W     = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [GCNT_W-1:0] LAST_GUARD = GCNT_W'(GUARD_CYC - 1);
    localparam addr_t             LAST_ADDR  = addr_t'(NUM_COEF - 1);

    state_t            r_state;
    addr_t             r_cnt;
    logic [GCNT_W-1:0] r_guard;
    logic              r_csn;
    logic              r_wrn;
    addr_t             r_addr;
    logic [COEF_W-1:0] r_wrdt;
    logic              r_flag;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;

    state_t            w_state_nxt;
    addr_t             w_cnt_nxt;
    logic [GCNT_W-1:0] w_guard_nxt;
    logic              w_csn_nxt;
    logic              w_wrn_nxt;
    addr_t             w_addr_nxt;
    logic [COEF_W-1:0] w_wrdt_nxt;
    logic              w_flag_nxt;
    logic              w_ready_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_acc_clr;
    logic              w_xfer;
    logic [COEF_W-1:0] w_wr_sum;

    // Ready is only ever high in FETCH, so a transfer implies FETCH.
    assign w_xfer = iCoefValid & r_ready;

    coef_sum_acc #(.W(COEF_W)) u_wr_sum (
        .i_clk   (iClk_12M),
        .i_rst_n (iRsn),
        .i_clr   (w_acc_clr),
        .i_en    (w_xfer),
        .i_data  (iCoefData),
        .o_sum   (w_wr_sum)
    );

`ifdef COEF_READBACK_EN
    logic              r_err;
    logic              r_rd_vld;
    logic              w_err_nxt;
    logic              w_rd_en;
    logic [COEF_W-1:0] w_rd_sum;
    logic [COEF_W-1:0] w_rd_total;

    // Read data trails the read strobe by one cycle; the last word arrives during CHK
    // and is folded in combinationally so CHK decides in a single cycle.
    assign w_rd_en    = r_rd_vld & (r_state == ST_RD);
    assign w_rd_total = w_rd_sum + iRdDt;

    coef_sum_acc #(.W(COEF_W)) u_rd_sum (
        .i_clk   (iClk_12M),
        .i_rst_n (iRsn),
        .i_clr   (w_acc_clr),
        .i_en    (w_rd_en),
        .i_data  (iRdDt),
        .o_sum   (w_rd_sum)
    );

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            r_err    <= 1'b0;
            r_rd_vld <= 1'b0;
        end else begin
            r_err    <= w_err_nxt;
            r_rd_vld <= (r_state == ST_RD);
        end
    end

    assign oErr = r_err;
`else
    logic w_unused;
    assign w_unused = ^{w_wr_sum, iRdDt};
    assign oErr     = 1'b0;
`endif

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_guard <= '0;
            r_csn   <= 1'b1;
            r_wrn   <= 1'b1;
            r_addr  <= '0;
            r_wrdt  <= '0;
            r_flag  <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_guard <= w_guard_nxt;
            r_csn   <= w_csn_nxt;
            r_wrn   <= w_wrn_nxt;
            r_addr  <= w_addr_nxt;
            r_wrdt  <= w_wrdt_nxt;
            r_flag  <= w_flag_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        // NOTE: every next-state value gets a default first, so no path infers a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_guard_nxt = r_guard;
        w_csn_nxt   = 1'b1;
        w_wrn_nxt   = 1'b1;
        w_addr_nxt  = r_addr;
        w_wrdt_nxt  = r_wrdt;
        w_flag_nxt  = r_flag;
        w_ready_nxt = 1'b0;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_acc_clr   = 1'b0;
`ifdef COEF_READBACK_EN
        w_err_nxt   = r_err;
`endif

        case (r_state)
            ST_IDLE: begin
                if (iStart) begin
                    w_state_nxt = ST_GUARD_IN;
                    w_flag_nxt  = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_guard_nxt = '0;
                    w_acc_clr   = 1'b1;
`ifdef COEF_READBACK_EN
                    w_err_nxt   = 1'b0;
`endif
                end
            end

            ST_GUARD_IN: begin
                if (r_guard == LAST_GUARD) begin
                    w_state_nxt = ST_FETCH;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_guard_nxt = r_guard + GCNT_W'(1);
                end
            end

            ST_FETCH: begin
                if (w_xfer) begin
                    w_state_nxt = ST_WRITE;
                    w_addr_nxt  = r_cnt;
                    w_wrdt_nxt  = iCoefData;
                    w_csn_nxt   = 1'b0;
                    w_wrn_nxt   = 1'b0;
                end else begin
                    w_ready_nxt = 1'b1;
                end
            end

            ST_WRITE: begin
                if (r_cnt == LAST_ADDR) begin
`ifdef COEF_READBACK_EN
                    w_state_nxt = ST_RD;
                    w_cnt_nxt   = '0;
                    w_addr_nxt  = '0;
                    w_csn_nxt   = 1'b0;
`else
                    w_state_nxt = ST_GUARD_OUT;
                    w_guard_nxt = '0;
`endif
                end else begin
                    w_state_nxt = ST_FETCH;
                    w_cnt_nxt   = r_cnt + addr_t'(1);
                    w_ready_nxt = 1'b1;
                end
            end

`ifdef COEF_READBACK_EN
            ST_RD: begin
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_CHK;
                end else begin
                    w_cnt_nxt   = r_cnt + addr_t'(1);
                    w_addr_nxt  = r_cnt + addr_t'(1);
                    w_csn_nxt   = 1'b0;
                end
            end

            ST_CHK: begin
                w_err_nxt   = (w_rd_total != w_wr_sum);
                w_state_nxt = ST_GUARD_OUT;
                w_guard_nxt = '0;
            end
`endif

            ST_GUARD_OUT: begin
                if (r_guard == LAST_GUARD) begin
                    w_state_nxt = ST_DONE;
                    w_flag_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_guard_nxt = r_guard + GCNT_W'(1);
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign oCoefReady  = r_ready;
    assign oAddr       = r_addr;
    assign oCsn        = r_csn;
    assign oWrn        = r_wrn;
    assign oWrDt       = r_wrdt;
    assign oUpdateFlag = r_flag;
    assign oBusy       = r_busy;
    assign oDone       = r_done;

endmodule

// File: tb/tb_coef_load_master.sv
// Scoreboard bench for coef_load_master: expected bus accesses are queued by the
// stimulus and popped by a monitor whenever the DUT drives oCsn low.
`timescale 1ns/1ps
module tb_coef_load_master;

    typedef struct packed {
        logic        wr;
        logic [5:0]  addr;
        logic [15:0] data;
    } bus_t;

`ifdef COEF_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        start      = 1'b0;
    logic        coef_valid = 1'b0;
    logic [15:0] coef_data  = '0;
    logic [15:0] rd_dt      = '0;
    logic        coef_ready, csn, wrn, flag, busy, done, err;
    logic [5:0]  addr;
    logic [15:0] wrdt;

    logic        s_start = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data  = '0;
    logic [15:0] s_rd_dt = '0;
    logic [15:0] s_mem   = '0;
    logic        s_ready, s_csn, s_wrn, s_flag, s_busy, s_done, s_err;
    logic [5:0]  s_addr;
    logic [15:0] s_wrdt;

    logic [15:0] mem [64];
    logic        corrupt = 1'b0;

    bus_t exp_q[$];
    bus_t s_q[$];
    bus_t mon_e;
    bus_t s_mon_e;

    int   n_cmp = 0;
    int   n_err = 0;
    int   wr_cnt = 0, done_cnt = 0, s_wr_cnt = 0, s_done_cnt = 0;
    int   flag_rise_cyc, first_csn_cyc;
    logic err_c1;

    always #5 clk = ~clk;

    coef_load_master #(.NUM_COEF(64), .COEF_W(16), .GUARD_CYC(2)) u_dut (
        .iClk_12M   (clk),
        .iRsn       (rst_n),
        .iStart     (start),
        .iCoefValid (coef_valid),
        .iCoefData  (coef_data),
        .oCoefReady (coef_ready),
        .oAddr      (addr),
        .oCsn       (csn),
        .oWrn       (wrn),
        .oWrDt      (wrdt),
        .iRdDt      (rd_dt),
        .oUpdateFlag(flag),
        .oBusy      (busy),
        .oDone      (done),
        .oErr       (err)
    );

    coef_load_master #(.NUM_COEF(1), .COEF_W(16), .GUARD_CYC(1)) u_small (
        .iClk_12M   (clk),
        .iRsn       (rst_n),
        .iStart     (s_start),
        .iCoefValid (s_valid),
        .iCoefData  (s_data),
        .oCoefReady (s_ready),
        .oAddr      (s_addr),
        .oCsn       (s_csn),
        .oWrn       (s_wrn),
        .oWrDt      (s_wrdt),
        .iRdDt      (s_rd_dt),
        .oUpdateFlag(s_flag),
        .oBusy      (s_busy),
        .oDone      (s_done),
        .oErr       (s_err)
    );

    // RAM models: 1-cycle read latency; optional +1 corruption at address 40.
    always @(posedge clk) begin
        if (!csn && !wrn) mem[addr] <= wrdt;
        if (!csn && wrn)  rd_dt <= mem[addr] + ((corrupt && addr == 6'd40) ? 16'd1 : 16'd0);
        if (!s_csn && !s_wrn) s_mem <= s_wrdt;
        if (!s_csn && s_wrn)  s_rd_dt <= s_mem;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    always @(negedge clk) begin
        if (rst_n && !csn) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL bus_unexpected: actual addr=%0d wrn=%0b, required no access", addr, wrn);
            end else begin
                mon_e = exp_q.pop_front();
                check("bus_wrn", 32'(wrn), 32'(!mon_e.wr));
                check("bus_addr", 32'(addr), 32'(mon_e.addr));
                if (mon_e.wr) check("bus_wrdt", 32'(wrdt), 32'(mon_e.data));
            end
            if (!wrn) wr_cnt++;
        end
        if (rst_n && done) begin
            done_cnt++;
            check("done_flag_low", 32'(flag), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (rst_n && !s_csn) begin
            if (s_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL small_bus_unexpected: actual addr=%0d wrn=%0b, required no access", s_addr, s_wrn);
            end else begin
                s_mon_e = s_q.pop_front();
                check("small_bus_wrn", 32'(s_wrn), 32'(!s_mon_e.wr));
                check("small_bus_addr", 32'(s_addr), 32'(s_mon_e.addr));
                if (s_mon_e.wr) check("small_bus_wrdt", 32'(s_wrdt), 32'(s_mon_e.data));
            end
            if (!s_wrn) s_wr_cnt++;
        end
        if (rst_n && s_done) s_done_cnt++;
    end

    task automatic push_exp(input int n_wr, input bit reads);
        bus_t b;
        for (int k = 0; k < n_wr; k++) begin
            b.wr = 1'b1; b.addr = 6'(k); b.data = 16'(16'h0100 + k);
            exp_q.push_back(b);
        end
        if (reads && READBACK) begin
            for (int k = 0; k < 64; k++) begin
                b.wr = 1'b0; b.addr = 6'(k); b.data = '0;
                exp_q.push_back(b);
            end
        end
    endtask

    // Drives one load: iStart in cycle 0, then coefficient k = 0x0100+k as ready allows.
    task automatic run_load(input int n, input int stall_after, input int stall_len,
                            input int restart_at, input int abort_at);
        int k = 0;
        int c = 0;
        int stall_cnt = 0;
        bit restarted = 1'b0;
        flag_rise_cyc = -1;
        first_csn_cyc = -1;
        while (k < n && c < 1000) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 0) begin
                start = 1'b1;
            end else if (restart_at >= 0 && k == restart_at && !restarted) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
            coef_valid = !(k == stall_after && stall_cnt < stall_len);
            coef_data  = 16'(16'h0100 + k);
            #1;
            if (c == 1) err_c1 = err;
            if (flag_rise_cyc < 0 && flag) flag_rise_cyc = c;
            if (first_csn_cyc < 0 && !csn) first_csn_cyc = c;
            if (abort_at >= 0 && !csn && !wrn && int'(addr) == abort_at) begin
                rst_n      = 1'b0;
                start      = 1'b0;
                coef_valid = 1'b0;
                #1;
                check("abort_csn", 32'(csn), 32'd1);
                check("abort_wrn", 32'(wrn), 32'd1);
                check("abort_flag", 32'(flag), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_ready", 32'(coef_ready), 32'd0);
                check("abort_addr", 32'(addr), 32'd0);
                return;
            end
            if (!coef_valid) begin
                stall_cnt++;
                if (coef_ready) begin
                    check("stall_bus_idle", 32'(csn), 32'd1);
                    check("stall_flag_held", 32'(flag), 32'd1);
                end
            end
            if (coef_valid && coef_ready) k++;
            c++;
        end
        if (k < n) fail_now("load_feed_timeout");
        @(negedge clk);
        start      = 1'b0;
        coef_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (busy && c < 600) begin
            @(negedge clk);
            c++;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: busy still high after %0d cycles", tag, c);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic load_checks(input string tag, input int n_wr);
        check({tag, "_writes"}, 32'(wr_cnt), 32'(n_wr));
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_flag_low"}, 32'(flag), 32'd0);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    task automatic full_load(input string tag, input int stall_after, input int restart_at);
        wr_cnt   = 0;
        done_cnt = 0;
        push_exp(64, 1'b1);
        run_load(64, stall_after, 5, restart_at, -1);
        wait_idle(tag);
        load_checks(tag, 64);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        repeat (3) @(negedge clk);
        check("rst_csn", 32'(csn), 32'd1);
        check("rst_wrn", 32'(wrn), 32'd1);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_wrdt", 32'(wrdt), 32'd0);
        check("rst_flag", 32'(flag), 32'd0);
        check("rst_ready", 32'(coef_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Unstalled load: flag one cycle after iStart, first strobe GUARD_CYC+2 after.
        full_load("plain", -1, -1);
        check("flag_rise_cyc", 32'(flag_rise_cyc), 32'd1);
        check("first_access_cyc", 32'(first_csn_cyc), 32'd4);
        check("err_after_plain", 32'(err), 32'd0);
        check("wrdt_holds_last", 32'(wrdt), 32'h013F);

        full_load("stall", 17, -1);
        full_load("restart", -1, 30);

        // Single-coefficient instance with one guard cycle.
        s_q.push_back('{wr: 1'b1, addr: 6'd0, data: 16'hBEEF});
        if (READBACK) s_q.push_back('{wr: 1'b0, addr: 6'd0, data: 16'h0000});
        s_data  = 16'hBEEF;
        s_valid = 1'b1;
        @(negedge clk);
        s_start = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            s_start = 1'b0;
            c++;
        end while (s_csn && c < 50);
        check("small_first_access_cyc", 32'(c), 32'd3);
        c = 0;
        while (s_busy && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (s_busy) fail_now("small_done_timeout");
        repeat (10) @(negedge clk);
        s_valid = 1'b0;
        check("small_writes", 32'(s_wr_cnt), 32'd1);
        check("small_done_pulses", 32'(s_done_cnt), 32'd1);
        check("small_queue_empty", 32'(s_q.size()), 32'd0);
        check("small_wrdt_holds", 32'(s_wrdt), 32'hBEEF);
        check("small_ready_idle", 32'(s_ready), 32'd0);
        check("small_flag_low", 32'(s_flag), 32'd0);
        check("small_err", 32'(s_err), 32'd0);

`ifdef COEF_READBACK_EN
        corrupt = 1'b1;
        full_load("rb_corrupt", -1, -1);
        check("rb_err_set", 32'(err), 32'd1);
        repeat (8) @(negedge clk);
        check("rb_err_held", 32'(err), 32'd1);
        corrupt = 1'b0;
        full_load("rb_clean", -1, -1);
        check("rb_err_cleared_on_start", 32'(err_c1), 32'd0);
        check("rb_err_clean", 32'(err), 32'd0);
`endif

        // Asynchronous reset while the write to address 10 is on the bus.
        wr_cnt   = 0;
        done_cnt = 0;
        push_exp(11, 1'b0);
        run_load(64, -1, 0, -1, 10);
        check("abort_writes_seen", 32'(wr_cnt), 32'd11);
        check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_abort_busy", 32'(busy), 32'd0);
        check("post_abort_flag", 32'(flag), 32'd0);
        check("post_abort_done_pulses", 32'(done_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
